// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : data_mem_ctrl_pkg
//  Brief  : Shared encodings for the data-memory controller (lane masks, FSM).
//  Rev    : 1.0  initial release
// ============================================================================
package data_mem_ctrl_pkg;

    localparam logic [2:0]  C_MASK_BYTE     = 3'b001;
    localparam logic [2:0]  C_MASK_HALF     = 3'b011;
    localparam logic [2:0]  C_MASK_WORD     = 3'b111;
    localparam logic [31:0] C_LED_ADDR_DFLT = 32'h0000_2000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_WR_RD   = 3'd2,
        ST_WR_WR   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic is_half(input logic [3:0] mask);
        return (mask[2:0] == C_MASK_HALF);
    endfunction

    function automatic logic is_word(input logic [3:0] mask);
        return (mask[2:0] == C_MASK_WORD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : data_mem_ctrl_if
//  Brief  : Core-side request/response and BRAM-side signals of the controller.
//  Rev    : 1.0  initial release
// ============================================================================
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 10
) ();
    logic [31:0]       addr;
    logic [31:0]       write_data;
    logic              memwrite;
    logic              memread;
    logic [3:0]        sign_mask;
    logic [31:0]       read_data;
    logic              stall;
    logic              misaligned;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_we;
    logic [31:0]       bram_wdata;
    logic [31:0]       bram_rdata;
    logic [7:0]        led;

    // Master is the core plus its BRAM; slave is the controller.
    modport master (
        output addr, write_data, memwrite, memread, sign_mask, bram_rdata,
        input  read_data, stall, misaligned, bram_addr, bram_we, bram_wdata, led
    );

    modport slave (
        input  addr, write_data, memwrite, memread, sign_mask, bram_rdata,
        output read_data, stall, misaligned, bram_addr, bram_we, bram_wdata, led
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
//  Module : data_lane_align
//  Brief  : Lane extract + sign/zero extend for loads, lane merge for stores.
//  Rev    : 1.0  initial release
// ============================================================================
module data_lane_align
    import data_mem_ctrl_pkg::*;
(
    input  wire logic [31:0] i_word,
    input  wire logic [31:0] i_wr_data,
    input  wire logic [1:0]  i_lane,
    input  wire logic [3:0]  i_sign_mask,
    output logic      [31:0] o_load,
    output logic      [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sext;

    assign w_byte = i_word[8*i_lane +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    assign w_sext = i_sign_mask[3];

    always_comb begin
        o_load   = i_word;
        o_merged = i_wr_data;
        case (i_sign_mask[2:0])
            C_MASK_BYTE: begin
                o_load                  = {{24{w_sext & w_byte[7]}}, w_byte};
                o_merged                = i_word;
                o_merged[8*i_lane +: 8] = i_wr_data[7:0];
            end
            C_MASK_HALF: begin
                // Half lane is chosen by addr[1] alone; addr[0] is ignored.
                o_load = {{16{w_sext & w_half[15]}}, w_half};
                if (i_lane[1]) o_merged = {i_wr_data[15:0], i_word[15:0]};
                else           o_merged = {i_word[31:16], i_wr_data[15:0]};
            end
            default: begin
                o_load   = i_word;
                o_merged = i_wr_data;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : data_mem_ctrl
//  Brief  : Data-memory responder: BRAM loads/stores with sub-word RMW, LED reg.
//  Rev    : 1.0  initial release
// ============================================================================
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] LED_ADDR = C_LED_ADDR_DFLT
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    data_mem_ctrl_if.slave  bus
);

    state_t      r_state;
    logic [31:0] r_read_data;
    logic [7:0]  r_led;
    logic        r_bram_we;
    logic [31:0] r_bram_wdata;

    logic        w_req;
    logic        w_accept;
    logic        w_is_led;
    logic        w_oor;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    assign w_req    = bus.memread | bus.memwrite;
    // Gated by rst_n so a request held through reset cannot raise stall.
    assign w_accept = rst_n & w_req & (r_state == ST_IDLE);
    assign w_is_led = (bus.addr == LED_ADDR);
    assign w_oor    = (|bus.addr[31:ADDR_W+2]) & ~w_is_led;

    assign bus.stall      = w_accept | ((r_state != ST_IDLE) && (r_state != ST_DONE));
    assign bus.misaligned = w_accept &
                            ((is_half(bus.sign_mask) & bus.addr[0]) |
                             (is_word(bus.sign_mask) & (|bus.addr[1:0])));
    assign bus.bram_addr  = bus.addr[ADDR_W+1:2];
    assign bus.bram_we    = r_bram_we;
    assign bus.bram_wdata = r_bram_wdata;
    assign bus.read_data  = r_read_data;
    assign bus.led        = r_led;

    data_lane_align u_lane (
        .i_word      (bus.bram_rdata),
        .i_wr_data   (bus.write_data),
        .i_lane      (bus.addr[1:0]),
        .i_sign_mask (bus.sign_mask),
        .o_load      (w_load_ext),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_read_data  <= '0;
            r_led        <= '0;
            r_bram_we    <= 1'b0;
            r_bram_wdata <= '0;
        end else begin
            r_bram_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_is_led) begin
                            if (bus.memwrite) r_led       <= bus.write_data[7:0];
                            else              r_read_data <= {24'b0, r_led};
                            r_state <= ST_DONE;
                        end else if (w_oor) begin
                            if (!bus.memwrite) r_read_data <= '0;
                            r_state <= ST_DONE;
                        end else if (bus.memwrite) begin
                            if (is_word(bus.sign_mask)) begin
                                r_bram_we    <= 1'b1;
                                r_bram_wdata <= bus.write_data;
                                r_state      <= ST_WR_WR;
                            end else begin
                                r_state <= ST_WR_RD;
                            end
                        end else begin
                            r_state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    r_read_data <= w_load_ext;
                    r_state     <= ST_DONE;
                end
                ST_WR_RD: begin
                    // Old word is on bram_rdata now; write back with the new lane.
                    r_bram_we    <= 1'b1;
                    r_bram_wdata <= w_merged;
                    r_state      <= ST_WR_WR;
                end
                ST_WR_WR: r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : tb_data_mem_ctrl
//  Brief  : Directed self-checking bench with BRAM model and load scoreboard.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

    localparam int          ADDR_W = 10;
    localparam logic [31:0] LED_A  = 32'h0000_2000;

    logic clk = 1'b0;
    logic rst_n;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    data_mem_ctrl #(.ADDR_W(ADDR_W), .LED_ADDR(LED_A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [31:0] mem    [0:(1<<ADDR_W)-1];
    logic [31:0] shadow [0:(1<<ADDR_W)-1];
    logic [7:0]  m_led;
    logic [31:0] exp_q [$];
    int          we_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_wdata;
        bus.bram_rdata <= mem[bus.bram_addr];
    end

    always @(negedge clk) if (bus.bram_we === 1'b1) we_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] m);
        logic [31:0] w;
        if (a == LED_A)              return {24'b0, m_led};
        if (a[31:ADDR_W+2] != '0)    return 32'h0;
        w = shadow[a[ADDR_W+1:2]];
        if (m[2:0] == 3'b001) begin
            w = w >> (8 * a[1:0]);
            return {{24{m[3] & w[7]}}, w[7:0]};
        end
        if (m[2:0] == 3'b011) begin
            w = w >> (16 * a[1]);
            return {{16{m[3] & w[15]}}, w[15:0]};
        end
        return w;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] msk;
        int          sh;
        if (a == LED_A) begin m_led = d[7:0]; return; end
        if (a[31:ADDR_W+2] != '0) return;
        if (m[2:0] == 3'b001)      begin sh = 8 * a[1:0]; msk = 32'hFF   << sh; end
        else if (m[2:0] == 3'b011) begin sh = 16 * a[1];  msk = 32'hFFFF << sh; end
        else                       begin sh = 0;          msk = 32'hFFFF_FFFF; end
        shadow[a[ADDR_W+1:2]] = (shadow[a[ADDR_W+1:2]] & ~msk) | ((d << sh) & msk);
    endtask

    // One core request: drive at a negedge, hold until stall drops, then release.
    task automatic access(input string tag, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          input int exp_stall, input logic exp_mis);
        int   n;
        int   we0;
        logic mis;
        logic done;
        logic to_bram;
        to_bram = (a != LED_A) && (a[31:ADDR_W+2] == '0);
        if (wr) model_store(a, d, m);
        else    exp_q.push_back(model_load(a, m));
        we0 = we_cnt;
        @(negedge clk);
        bus.addr = a; bus.write_data = d; bus.sign_mask = m;
        bus.memwrite = wr; bus.memread = ~wr;
        #1;
        n    = bus.stall ? 1 : 0;
        mis  = bus.misaligned;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (!bus.stall) done = 1'b1;
            else begin n++; mis |= bus.misaligned; end
        end
        bus.memwrite = 1'b0; bus.memread = 1'b0;
        #1;
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_stall"}, n, exp_stall);
        check({tag, "_misal"}, {31'b0, mis}, {31'b0, exp_mis});
        check({tag, "_we"}, we_cnt - we0, (wr && to_bram) ? 1 : 0);
        if (!wr) check({tag, "_rdata"}, bus.read_data, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin mem[i] = '0; shadow[i] = '0; end
        m_led = '0;
        rst_n = 1'b0;
        bus.addr = '0; bus.write_data = '0; bus.sign_mask = '0;
        bus.memwrite = 1'b0; bus.memread = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus.read_data, 32'h0);
        check("rst_led",   {24'b0, bus.led}, 32'h0);
        check("rst_we",    {31'b0, bus.bram_we}, 32'h0);
        check("rst_stall", {31'b0, bus.stall}, 32'h0);
        check("rst_misal", {31'b0, bus.misaligned}, 32'h0);
        rst_n = 1'b1;

        // Word store then word load
        access("t1_sw", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0111, 2, 1'b0);
        check("t1_mem", mem[4], 32'hDEAD_BEEF);
        access("t1_lw", 1'b0, 32'h10, 32'h0, 4'b1111, 2, 1'b0);
        check("t1_const", bus.read_data, 32'hDEAD_BEEF);

        // Byte RMW and signed/unsigned byte loads
        access("t2_sw", 1'b1, 32'h10, 32'h1122_3344, 4'b0111, 2, 1'b0);
        access("t2_sb", 1'b1, 32'h13, 32'h0000_0080, 4'b0001, 3, 1'b0);
        check("t2_mem", mem[4], 32'h8022_3344);
        access("t2_lb", 1'b0, 32'h13, 32'h0, 4'b1001, 2, 1'b0);
        check("t2_lb_const", bus.read_data, 32'hFFFF_FF80);
        access("t2_lbu", 1'b0, 32'h13, 32'h0, 4'b0001, 2, 1'b0);
        check("t2_lbu_const", bus.read_data, 32'h0000_0080);
        access("t2_lb1", 1'b0, 32'h11, 32'h0, 4'b1001, 2, 1'b0);

        // Half store to upper lane, loads from both halves
        access("t3_sh", 1'b1, 32'h22, 32'h0000_ABCD, 4'b0011, 3, 1'b0);
        check("t3_mem", mem[8], 32'hABCD_0000);
        access("t3_lh", 1'b0, 32'h22, 32'h0, 4'b1011, 2, 1'b0);
        check("t3_lh_const", bus.read_data, 32'hFFFF_ABCD);
        access("t3_lhu", 1'b0, 32'h20, 32'h0, 4'b0011, 2, 1'b0);
        access("t3_lh_mis", 1'b0, 32'h23, 32'h0, 4'b0011, 2, 1'b1);

        // LED register
        access("t4_led_st", 1'b1, LED_A, 32'h0000_00A5, 4'b0111, 1, 1'b0);
        check("t4_led", {24'b0, bus.led}, 32'h0000_00A5);
        access("t4_led_ld", 1'b0, LED_A, 32'h0, 4'b1111, 1, 1'b0);
        check("t4_led_const", bus.read_data, 32'h0000_00A5);

        // Out of range and misaligned word
        access("t5_oor_ld", 1'b0, 32'h0010_0000, 32'h0, 4'b1111, 1, 1'b0);
        access("t5_oor_st", 1'b1, 32'h0010_0004, 32'h1234_5678, 4'b0111, 1, 1'b0);
        access("t5_mis_lw", 1'b0, 32'h11, 32'h0, 4'b1111, 2, 1'b1);
        check("t5_mis_const", bus.read_data, 32'h8022_3344);

        // Reset during the read phase of a byte store
        access("t6_pre", 1'b1, 32'h14, 32'h5566_7788, 4'b0111, 2, 1'b0);
        begin
            int we0;
            we0 = we_cnt;
            @(negedge clk);
            bus.addr = 32'h14; bus.write_data = 32'hFF; bus.sign_mask = 4'b0001;
            bus.memwrite = 1'b1;
            @(negedge clk);
            check("t6_in_wr_rd", {31'b0, bus.stall}, 32'd1);
            rst_n = 1'b0;
            #1;
            check("t6_stall", {31'b0, bus.stall}, 32'd0);
            check("t6_we_now", {31'b0, bus.bram_we}, 32'd0);
            repeat (2) @(negedge clk);
            bus.memwrite = 1'b0;
            rst_n = 1'b1;
            m_led = '0;
            repeat (2) @(negedge clk);
            check("t6_we_cnt", we_cnt - we0, 0);
            check("t6_mem", mem[5], 32'h5566_7788);
            check("t6_rdata", bus.read_data, 32'h0);
            check("t6_led", {24'b0, bus.led}, 32'h0);
        end
        access("t6_post_lw", 1'b0, 32'h14, 32'h0, 4'b1111, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
